// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port data memory: CPU port C has priority,
// port D is force-granted after MAX_WAIT held-off cycles. Responses are one cycle after grant.
module data_mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [2:0]            c_funct3,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  c_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [2:0]            d_funct3,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;
   logic             force_d;
   logic             c_legal;
   logic             d_legal;

   // Legal funct3 for the access direction, with natural alignment for halfword/word
   function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = !a[0];
         3'b010:  ok = (a == 2'b00);
         3'b100:  ok = !we;
         3'b101:  ok = !we && !a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign c_legal = is_legal(c_we, c_funct3, c_addr[1:0]);
   assign d_legal = is_legal(d_we, d_funct3, d_addr[1:0]);

   assign force_d = d_req && (wait_cnt == WAIT_MAX);
   assign c_gnt   = c_req && !force_d;
   assign d_gnt   = d_req && (!c_req || force_d);

   // Winner's request drives the memory; idle bus parks on a harmless word read of 0
   always_comb begin
      mem_wr_en   = 1'b0;
      mem_funct3  = 3'b010;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (c_gnt) begin
         mem_wr_en   = c_we && c_legal;
         mem_funct3  = c_funct3;
         mem_addr    = c_addr;
         mem_wr_data = c_wdata;
      end else if (d_gnt) begin
         mem_wr_en   = d_we && d_legal;
         mem_funct3  = d_funct3;
         mem_addr    = d_addr;
         mem_wr_data = d_wdata;
      end
   end

   // Starvation counter for port D
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!d_req || d_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Port C response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_rvalid <= 1'b0;
         c_err    <= 1'b0;
         c_rdata  <= '0;
      end else begin
         c_rvalid <= c_gnt;
         if (c_gnt) begin
            c_err   <= !c_legal;
            c_rdata <= (!c_we && c_legal) ? mem_rd_data : '0;
         end
      end
   end

   // Port D response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= '0;
      end else begin
         d_rvalid <= d_gnt;
         if (d_gnt) begin
            d_err   <= !d_legal;
            d_rdata <= (!d_we && d_legal) ? mem_rd_data : '0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a byte-addressed memory model behind the arbiter.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, c_we, d_req, d_we;
   logic [2:0]  c_funct3, d_funct3;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_wr_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t c_q[$];
   exp_t d_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic [7:0] mem [0:255];

   data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: combinational extended read, store commits on the clock edge
   always_comb begin
      logic [7:0] a;
      a = mem_addr[7:0];
      case (mem_funct3)
         3'b000:  mem_rd_data = {{24{mem[a][7]}}, mem[a]};
         3'b001:  mem_rd_data = {{16{mem[8'(a+1)][7]}}, mem[8'(a+1)], mem[a]};
         3'b100:  mem_rd_data = {24'h0, mem[a]};
         3'b101:  mem_rd_data = {16'h0, mem[8'(a+1)], mem[a]};
         default: mem_rd_data = {mem[8'(a+3)], mem[8'(a+2)], mem[8'(a+1)], mem[a]};
      endcase
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr[7:0]] <= mem_wr_data[7:0];
         if (mem_funct3 != 3'b000) mem[8'(mem_addr[7:0]+1)] <= mem_wr_data[15:8];
         if (mem_funct3 == 3'b010) begin
            mem[8'(mem_addr[7:0]+2)] <= mem_wr_data[23:16];
            mem[8'(mem_addr[7:0]+3)] <= mem_wr_data[31:24];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      if (c_gnt || d_gnt) chk("one_gnt", 32'(c_gnt & d_gnt), 32'd0);
      if (c_rvalid) begin
         if (c_q.size() == 0) chk("c_unexpected_rvalid", 32'd1, 32'd0);
         else begin
            e = c_q.pop_front();
            chk("c_err", 32'(c_err), 32'(e.err));
            chk("c_rdata", c_rdata, e.rdata);
         end
      end
      if (d_rvalid) begin
         if (d_q.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
         else begin
            e = d_q.pop_front();
            chk("d_err", 32'(d_err), 32'(e.err));
            chk("d_rdata", d_rdata, e.rdata);
         end
      end
   end

   task automatic drive(input bit pd, input logic r, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (pd) begin
         d_req = r; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
      end else begin
         c_req = r; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd;
      end
   endtask

   // One transfer on port C (pd=0) or D (pd=1); returns the cycle number of its grant
   task automatic xfer(input bit pd, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                       input bit push, output int gcyc);
      int  n;
      bit  got;
      n = 0;
      got = 1'b0;
      gcyc = -1;
      drive(pd, 1'b1, we, f3, addr, wd);
      while (!got && n < 20) begin
         @(negedge clk);
         if (pd ? d_gnt : c_gnt) got = 1'b1;
         else n++;
      end
      if (!got) begin
         chk(pd ? "d_gnt_timeout" : "c_gnt_timeout", 32'd0, 32'd1);
         drive(pd, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         return;
      end
      gcyc = cyc;
      chk("mem_wr_en", 32'(mem_wr_en), 32'(we & !eerr));
      if (push) begin
         if (pd) d_q.push_back('{err: eerr, rdata: erd});
         else    c_q.push_back('{err: eerr, rdata: erd});
      end
      @(posedge clk);
      #1;
      drive(pd, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, g0, g1, g2, g3, g4, gd;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_c_rdata", c_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_errs", 32'({c_err, d_err}), 32'd0);
      chk("idle_mem_funct3", 32'(mem_funct3), 32'd2);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // sw / lw round trip on C
      xfer(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, g0);
      xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, g0);
      // misaligned store rejected, memory untouched
      xfer(0, 1, 3'b010, 32'h12, 32'h12345678, 1, 32'h0, 1, g0);
      xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, g0);
      // byte store and extended loads on D
      xfer(1, 1, 3'b000, 32'h13, 32'h000000AB, 0, 32'h0, 1, g0);
      xfer(1, 0, 3'b100, 32'h13, 32'h0, 0, 32'h000000AB, 1, g0);
      xfer(1, 0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFFAB, 1, g0);
      xfer(1, 0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFABAD, 1, g0);
      xfer(1, 0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1, g0);
      xfer(1, 0, 3'b101, 32'h11, 32'h0, 1, 32'h0, 1, g0);

      // Simultaneous requests: C 2-cycle burst first, then D
      k = cyc;
      fork
         begin
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g0);
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g1);
         end
         xfer(1, 0, 3'b100, 32'h10, 32'h0, 0, 32'h000000EF, 1, gd);
      join
      chk("burst_c0_cycle", 32'(g0 - k), 32'd0);
      chk("burst_c1_cycle", 32'(g1 - k), 32'd1);
      chk("burst_d_cycle", 32'(gd - k), 32'd2);

      // D withdraws its request before being granted: nothing issued
      fork
         begin
            xfer(0, 0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 1, g0);
            xfer(0, 0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 1, g1);
         end
         begin
            drive(1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h55555555);
            @(negedge clk);
            chk("d_held_off", 32'(d_gnt), 32'd0);
            @(posedge clk); #1;
            drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         end
      join
      @(posedge clk); #1;

      // Starvation: C requests continuously, D forced in on its 5th cycle
      k = cyc;
      fork
         begin
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g0);
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g1);
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g2);
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g3);
            xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g4);
         end
         xfer(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, gd);
      join
      chk("force_d_cycle", 32'(gd - k), 32'd4);
      chk("c_after_force_cycle", 32'(g4 - k), 32'd5);
      chk("c_third_cycle", 32'(g3 - k), 32'd3);
      chk("wait_cnt_cleared", 32'(dut.wait_cnt), 32'd0);

      // Reset right after a granted load discards its response
      xfer(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 0, g0);
      chk("pre_rst_d_rvalid", 32'(d_rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_d_rvalid_now", 32'(d_rvalid), 32'd0);
      chk("rst_d_rdata_now", d_rdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      k = cyc;
      fork
         xfer(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, g0);
         xfer(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABADBEEF, 1, gd);
      join
      chk("post_rst_c_first", 32'(g0 - k), 32'd0);
      chk("post_rst_d_second", 32'(gd - k), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("c_q_drained", 32'(c_q.size()), 32'd0);
      chk("d_q_drained", 32'(d_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
